ysyx_25040118_lsu: RTL

YSYX_25040118_LSU -- requirements
Module: ysyx_25040118_lsu

---
 rtl/ysyx_25040118_lsu_pkg.sv | 39 +++
 rtl/ysyx_25040118_lsu_align.sv | 59 +++++
 rtl/ysyx_25040118_lsu.sv | 117 +++++++++++
 3 files changed

// File: rtl/ysyx_25040118_lsu_pkg.sv
`default_nettype none
// =============================================================================
// ysyx_25040118_lsu_pkg -- LSU funct3 codes, FSM state type, access check. Rev 1.0
// =============================================================================
package ysyx_25040118_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_e;

  // funct3[1:0] encodes the access size for every legal load/store
  function automatic logic access_err(input logic       is_store,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic legal;
    logic misaligned;
    if (is_store) legal = funct3 inside {F3_SB, F3_SH, F3_SW};
    else          legal = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    return !legal || misaligned;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_25040118_lsu_align.sv
`default_nettype none
// =============================================================================
// ysyx_25040118_lsu_align -- store lane replication/strobes and load extension. Rev 1.0
// =============================================================================
module ysyx_25040118_lsu_align
  import ysyx_25040118_lsu_pkg::*;
(
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [31:0]       wdata,
  input  logic [31:0]       rdata,
  output logic [STRB_W-1:0] wstrb,
  output logic [31:0]       wdata_lane,
  output logic [31:0]       load_data
);

  logic [31:0] rshift;

  assign rshift = rdata >> {addr_lo, 3'b000};

  always_comb begin
    wstrb      = '0;
    wdata_lane = '0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          wstrb      = 4'b0001 << addr_lo;
          wdata_lane = {4{wdata[7:0]}};
        end
        2'b01: begin
          wstrb      = 4'b0011 << addr_lo;
          wdata_lane = {2{wdata[15:0]}};
        end
        default: begin
          wstrb      = 4'b1111;
          wdata_lane = wdata;
        end
      endcase
    end
  end

  // stores acknowledge with a zero result
  always_comb begin
    load_data = '0;
    if (!is_store) begin
      case (funct3)
        F3_LB:   load_data = {{24{rshift[7]}}, rshift[7:0]};
        F3_LH:   load_data = {{16{rshift[15]}}, rshift[15:0]};
        F3_LW:   load_data = rshift;
        F3_LBU:  load_data = {24'd0, rshift[7:0]};
        F3_LHU:  load_data = {16'd0, rshift[15:0]};
        default: load_data = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_25040118_lsu.sv
`default_nettype none
// =============================================================================
// ysyx_25040118_lsu -- single-outstanding load/store unit with timeout. Rev 1.0
// =============================================================================
module ysyx_25040118_lsu
  import ysyx_25040118_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_load,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [31:0]       mem_addr,
  output logic              mem_wen,
  output logic [31:0]       mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e       state;
  lsu_state_e       state_nxt;
  logic             is_store_q;
  logic [2:0]       funct3_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept;
  logic             req_err;
  logic             timeout;
  logic [31:0]      load_data;

  assign accept  = req_valid && req_ready;
  // an inconsistent access type is rejected like an illegal funct3
  assign req_err = access_err(req_is_store, req_funct3, req_addr[1:0]) ||
                   (req_is_load == req_is_store);
  assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  assign req_ready     = (state == S_IDLE);
  assign resp_valid    = (state == S_RESP);
  assign mem_req_valid = (state == S_ISSUE);
  assign mem_addr      = {addr_q[31:2], 2'b00};
  assign mem_wen       = is_store_q;

  ysyx_25040118_lsu_align u_align (
    .is_store   (is_store_q),
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (mem_resp_rdata),
    .wstrb      (mem_wstrb),
    .wdata_lane (mem_wdata),
    .load_data  (load_data)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = req_err ? S_RESP : S_ISSUE;
      S_ISSUE: if (mem_req_ready) state_nxt = S_WAIT;
      S_WAIT:  if (mem_resp_valid || timeout) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wait_cnt   <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        is_store_q <= req_is_store;
        funct3_q   <= req_funct3;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        resp_data  <= '0;
        resp_err   <= req_err;
      end
      if (state == S_ISSUE)     wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
      // a response arriving on the last allowed cycle still wins over timeout
      if (state == S_WAIT) begin
        if (mem_resp_valid) begin
          resp_data <= load_data;
          resp_err  <= 1'b0;
        end else if (timeout) begin
          resp_data <= '0;
          resp_err  <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
